// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, default sizes and the access legality check for mem_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam int ADDR_W_DEF = 9;
  localparam int STARVE_MAX_DEF = 4;
  function automatic logic addr_legal(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> aw) == 32'd0);
  endfunction
endpackage

// File: rtl/mem_arb_resp.sv
// mem_arb_resp: remembers who owns the in-flight access and steers the next-cycle response to it.
module mem_arb_resp
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_gnt_i,
  input  logic        d_gnt_i,
  input  logic        err_i,
  input  logic        store_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o
);
  owner_t owner_q, owner_d;
  logic   err_q, err_d;
  logic   store_q, store_d;
  always_comb begin
    owner_d = d_gnt_i ? OWN_D : if_gnt_i ? OWN_IF : OWN_NONE;
    err_d   = (d_gnt_i || if_gnt_i) && err_i;
    store_d = d_gnt_i && store_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      store_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      store_q <= store_d;
    end
  end
  // Errors and store acks carry zero data; only good reads expose mem_rdata.
  always_comb begin
    if_rvalid_o = owner_q == OWN_IF;
    if_err_o    = if_rvalid_o && err_q;
    if_rdata_o  = (if_rvalid_o && !err_q) ? mem_rdata_i : 32'd0;
    d_rvalid_o  = owner_q == OWN_D;
    d_err_o     = d_rvalid_o && err_q;
    d_rdata_o   = (d_rvalid_o && !err_q && !store_q) ? mem_rdata_i : 32'd0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for one single-port word memory with alignment and range checks.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch through after STARVE_MAX back-to-back data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  logic        force_if;
  logic [31:0] addr;
  logic        legal;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;
  assign force_if = if_req && d_req && (starve_q == CW'(STARVE_MAX));
  assign starve_d = (if_gnt || !if_req) ? '0 : d_gnt ? starve_q + 1'b1 : starve_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif
  // Grants are held low during reset so nothing reaches the memory.
  always_comb begin
    d_gnt     = rst_n && d_req && !force_if;
    if_gnt    = rst_n && if_req && !d_gnt;
    addr      = d_gnt ? d_addr : if_addr;
    legal     = addr_legal(addr, ADDR_W);
    mem_en    = (d_gnt || if_gnt) && legal;
    mem_we    = mem_en && d_gnt && d_we;
    mem_be    = !mem_en ? 4'h0 : d_gnt ? d_be : 4'hF;
    mem_addr  = mem_en ? addr[ADDR_W-1:2] : '0;
    mem_wdata = (mem_en && d_gnt) ? d_wdata : 32'd0;
  end
  mem_arb_resp u_resp (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_gnt_i    (if_gnt),
    .d_gnt_i     (d_gnt),
    .err_i       (!legal),
    .store_i     (d_we),
    .mem_rdata_i (mem_rdata),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .if_err_o    (if_err),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .d_err_o     (d_err)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner-case sequences for mem_arbiter against a BRAM model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port BRAM with byte enables and one-cycle read latency, preloaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hAAAAAAAA;
      mem[4]   <= 32'hDEADBEEF;
      mem[127] <= 32'h0BADF00D;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_ignt;
    logic        e_dgnt;
    logic        e_en;
    logic        e_we;
    logic [6:0]  e_maddr;
    logic        e_irv;
    logic        e_drv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 10;
  vec_t v [NV];
  logic exp_if [10];

  initial begin
    v[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 7'd4,   1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    v[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h20,  32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 7'd8,   1'b0, 1'b1, 1'b0, 32'h0};
    v[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h20,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 7'd8,   1'b0, 1'b1, 1'b0, 32'hAAAA5678};
    v[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h22,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   1'b0, 1'b1, 1'b1, 32'h0};
    v[4] = '{1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 32'h0};
    v[5] = '{1'b1, 32'h10,  1'b1, 1'b0, 4'hF, 32'h20,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 7'd8,   1'b0, 1'b1, 1'b0, 32'hAAAA5678};
    v[6] = '{1'b1, 32'h1FC, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 1'b1, 1'b0, 1'b0, 32'h0BADF00D};
    v[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'hF, 32'h21,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   1'b0, 1'b1, 1'b1, 32'h0};
    v[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h20,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 7'd8,   1'b0, 1'b1, 1'b0, 32'hAAAA5678};
    v[9] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h400, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   1'b0, 1'b1, 1'b1, 32'h0};
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {31'd0, if_gnt | d_gnt | mem_en | if_rvalid | d_rvalid | if_err | d_err}, 32'd0);
    chk("reset_rdata", if_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_req = v[i].ireq; if_addr = v[i].iaddr;
      d_req = v[i].dreq; d_we = v[i].dwe; d_be = v[i].dbe; d_addr = v[i].daddr; d_wdata = v[i].dwdata;
      #1;
      chk($sformatf("v%0d_gnt", i), {30'd0, if_gnt, d_gnt}, {30'd0, v[i].e_ignt, v[i].e_dgnt});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, v[i].e_en});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, v[i].e_we});
      if (v[i].e_en) chk($sformatf("v%0d_mem_addr", i), {25'd0, mem_addr}, {25'd0, v[i].e_maddr});
      if (v[i].e_we) chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, v[i].dbe});
      if (v[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].dwdata);
      if (v[i].e_en && v[i].e_ignt) chk($sformatf("v%0d_fetch_be", i), {28'd0, mem_be}, 32'hF);
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("v%0d_rvalid", i), {30'd0, if_rvalid, d_rvalid}, {30'd0, v[i].e_irv, v[i].e_drv});
      chk($sformatf("v%0d_err", i), {31'd0, v[i].e_irv ? if_err : d_err}, {31'd0, v[i].e_err});
      chk($sformatf("v%0d_rdata", i), v[i].e_irv ? if_rdata : d_rdata, v[i].e_rdata);
    end

    // back-to-back: the response seen during a fetch grant belongs to the previous data load
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h10; d_be = 4'hF;
    #1 chk("b2b_dgnt", {31'd0, d_gnt}, 32'd1);
    @(negedge clk);
    idle(); if_req = 1'b1; if_addr = 32'h1FC;
    #1;
    chk("b2b_ignt", {31'd0, if_gnt}, 32'd1);
    chk("b2b_drv", {30'd0, if_rvalid, d_rvalid}, 32'd1);
    chk("b2b_drdata", d_rdata, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    #1;
    chk("b2b_irv", {30'd0, if_rvalid, d_rvalid}, 32'd2);
    chk("b2b_irdata", if_rdata, 32'h0BADF00D);

    // contention: data keeps winning, fetch gets in once data stops asking
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("cont%0d_gnt", k), {30'd0, if_gnt, d_gnt}, 32'd1);
      @(negedge clk);
    end
    d_req = 1'b0;
    #1 chk("cont_release_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
    @(negedge clk);
    idle();

    // starvation: grant pattern under continuous contention
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("starve%0d_gnt", k), {30'd0, if_gnt, d_gnt}, {30'd0, exp_if[k], !exp_if[k]});
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    // reset during the response cycle drops the pending fetch response
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1 chk("rst_pre_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {29'd0, if_gnt, mem_en, if_rvalid}, 32'd0);
    chk("rst_mid_rdata", if_rdata, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_rv0", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    @(negedge clk);
    #1 chk("rst_release_rv1", {30'd0, if_rvalid, d_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
